// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Holds the controller state encoding and the default operand width.
package serial_add_pkg;

   localparam int DEF_WIDTH = 8;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder built from two half-adder stages.
// Purely combinational; the controller reuses it once per bit.
module serial_fa_cell
   import serial_add_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   logic s1;
   logic c1;
   logic c2;

   // first half adder on the operand bits, second folds in carry
   always_comb begin
      s1 = x ^ y;
      c1 = x & y;
      s  = s1 ^ ci;
      c2 = s1 & ci;
      co = c1 | c2;
   end

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder cell, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered ovf output.
module bit_serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] areg;
   logic [WIDTH-1:0] breg;
   logic [WIDTH-1:0] sreg;
   logic             cout_r;
   logic             fs;
   logic             fc;
   logic [WIDTH:0]   snext;

   // operands shift right so bit 0 is always the live bit
   serial_fa_cell u_fa (
      .x  (areg[0]),
      .y  (breg[0]),
      .ci (carry),
      .s  (fs),
      .co (fc)
   );

   // new sum bit enters at the MSB and walks down
   always_comb begin
      snext = {fs, sreg} >> 1;
   end

   // handshake flags decode straight from state
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // controller, operand/result shifters and carry chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         carry  <= 1'b0;
         areg   <= '0;
         breg   <= '0;
         sreg   <= '0;
         cout_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  areg  <= a;
                  breg  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               areg  <= areg >> 1;
               breg  <= breg >> 1;
               sreg  <= snext[WIDTH-1:0];
               carry <= fc;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  cout_r <= fc;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sum  = sreg;
   assign cout = cout_r;

`ifdef SERIAL_ADD_OVF_EN
   logic ovf_r;

   // carry into the MSB vs carry out, captured on the last bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (state == RUN && cnt == LAST) begin
         ovf_r <= carry ^ fc;
      end
   end

   assign ovf = ovf_r;
`else
   // unsigned-only build: no overflow tracking
`endif

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Bench for bit_serial_add_ctrl: vector table, random ops
// against an arithmetic model, plus multi-cycle corner cases.
module tb_bit_serial_add_ctrl;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       cout;
   logic       ovf;

   logic       in_valid1;
   logic       in_ready1;
   logic       a1;
   logic       b1;
   logic       cin1;
   logic       out_valid1;
   logic       out_ready1;
   logic       sum1;
   logic       cout1;
   logic       ovf1;

   int total;
   int bad;

   bit_serial_add_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   bit_serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .a         (a1),
      .b         (b1),
      .cin       (cin1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .sum       (sum1),
      .cout      (cout1)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf       (ovf1)
`endif
   );

`ifndef SERIAL_ADD_OVF_EN
   assign ovf  = 1'b0;
   assign ovf1 = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h",
                  nm, act, exp);
      end
   endtask

   // a+b+cin as integers; ovf from signed range
   task automatic model(input logic [7:0] x,
                        input logic [7:0] y,
                        input logic c,
                        output logic [7:0] s,
                        output logic co,
                        output logic ov);
      int u;
      int sx;
      int sy;
      int r;
      u  = int'(x) + int'(y) + int'(c);
      s  = u[7:0];
      co = (u > 255);
      sx = x[7] ? int'(x) - 256 : int'(x);
      sy = y[7] ? int'(y) - 256 : int'(y);
      r  = sx + sy + int'(c);
      ov = (r > 127) || (r < -128);
   endtask

   // called #1 after an edge with the DUT idle
   task automatic run_op(input logic [7:0] x,
                         input logic [7:0] y,
                         input logic c,
                         input string tag);
      logic [7:0] es;
      logic eco;
      logic eov;
      int lat;
      model(x, y, c, es, eco, eov);
      in_valid = 1'b1;
      a = x;
      b = y;
      cin = c;
      chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
      chk({tag, ".busy"}, 64'(in_ready), 64'd0);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 3) begin
            a = 8'($urandom);
            b = 8'($urandom);
         end
      end
      chk({tag, ".lat"}, 64'(lat), 64'd8);
      chk({tag, ".sum"}, 64'(sum), 64'(es));
      chk({tag, ".cout"}, 64'(cout), 64'(eco));
`ifdef SERIAL_ADD_OVF_EN
      chk({tag, ".ovf"}, 64'(ovf), 64'(eov));
`endif
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, ".drop"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [7:0] hs;
      logic hc;
      int n;
      int seen;
      total = 0;
      bad = 0;

      vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[5] = '{8'h0F, 8'hF1, 1'b1, 8'h01, 1'b1, 1'b0};
      vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};

      rst_n = 1'b0;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      out_ready = 1'b0;
      in_valid1 = 1'b0;
      a1 = 1'b0;
      b1 = 1'b0;
      cin1 = 1'b0;
      out_ready1 = 1'b1;

      #2;
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.sum", 64'(sum), 64'd0);
      chk("rst.cout", 64'(cout), 64'd0);
      chk("rst.ovf", 64'(ovf), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst.in_ready", 64'(in_ready), 64'd1);

      // first accept on the first edge after release
      run_op(8'h12, 8'h34, 1'b0, "first");

      for (int i = 0; i < 7; i++) begin
         model(vecs[i].a, vecs[i].b, vecs[i].cin,
               hs, hc, seen[0]);
         chk($sformatf("tbl%0d.model", i),
             64'({hs, hc}),
             64'({vecs[i].s, vecs[i].co}));
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin,
                $sformatf("tbl%0d", i));
      end

      for (int i = 0; i < 40; i++) begin
         run_op(8'($urandom), 8'($urandom), 1'($urandom),
                $sformatf("rnd%0d", i));
      end

      // backpressure: DONE held, in_valid pulses ignored
      in_valid = 1'b1;
      a = 8'h3C;
      b = 8'h45;
      cin = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("bp.lat", 64'(n), 64'd8);
      for (int k = 0; k < 5; k++) begin
         in_valid = k[0];
         a = 8'($urandom);
         b = 8'($urandom);
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d.valid", k), 64'(out_valid), 64'd1);
         chk($sformatf("bp%0d.sum", k), 64'(sum), 64'h81);
         chk($sformatf("bp%0d.cout", k), 64'(cout), 64'd0);
         chk($sformatf("bp%0d.rdy", k), 64'(in_ready), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
         chk($sformatf("bp%0d.ovf", k), 64'(ovf), 64'd1);
`endif
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp.release", 64'(in_ready), 64'd1);

      // reset while bit 3 is pending
      in_valid = 1'b1;
      a = 8'h55;
      b = 8'hAA;
      cin = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid.out_valid", 64'(out_valid), 64'd0);
      chk("mid.sum", 64'(sum), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("mid.in_ready", 64'(in_ready), 64'd1);
      seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      chk("mid.no_result", 64'(seen), 64'd0);
      run_op(8'h01, 8'h02, 1'b0, "after_rst");

      // back-to-back with out_ready tied high
      out_ready = 1'b1;
      in_valid = 1'b1;
      a = 8'h10;
      b = 8'h20;
      cin = 1'b0;
      @(posedge clk);
      #1;
      a = 8'h0F;
      b = 8'hF1;
      cin = 1'b1;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("b2b.lat", 64'(n), 64'd8);
      chk("b2b.sum0", 64'(sum), 64'h30);
      chk("b2b.cout0", 64'(cout), 64'd0);
      @(posedge clk);
      #1;
      n = 1;
      chk("b2b.idle", 64'(out_valid), 64'd0);
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("b2b.period", 64'(n), 64'd10);
      chk("b2b.sum1", 64'(sum), 64'h01);
      chk("b2b.cout1", 64'(cout), 64'd1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("b2b.end", 64'(in_ready), 64'd1);

      // WIDTH=1: every input combination, one RUN cycle
      for (int k = 0; k < 8; k++) begin
         int u;
         int r;
         logic [2:0] kv;
         kv = 3'(k);
         a1 = kv[2];
         b1 = kv[1];
         cin1 = kv[0];
         u = int'(a1) + int'(b1) + int'(cin1);
         r = -int'(a1) - int'(b1) + int'(cin1);
         in_valid1 = 1'b1;
         chk($sformatf("w1_%0d.rdy", k), 64'(in_ready1), 64'd1);
         @(posedge clk);
         #1;
         in_valid1 = 1'b0;
         a1 = ~a1;
         b1 = ~b1;
         chk($sformatf("w1_%0d.run", k), 64'(out_valid1), 64'd0);
         @(posedge clk);
         #1;
         chk($sformatf("w1_%0d.valid", k), 64'(out_valid1), 64'd1);
         chk($sformatf("w1_%0d.sum", k), 64'(sum1), 64'(u % 2));
         chk($sformatf("w1_%0d.cout", k), 64'(cout1), 64'(u / 2));
`ifdef SERIAL_ADD_OVF_EN
         chk($sformatf("w1_%0d.ovf", k), 64'(ovf1),
             64'((r > 0) || (r < -1)));
`endif
         @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bit_serial_add_ctrl.md
BIT_SERIAL_ADD_CTRL -- requirements
Module: bit_serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal range 1..64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-004 SHALL have port in_valid, input, 1, operand set presented.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand set.
REQ-006 SHALL have ports a and b, input, WIDTH each, the operands, unsigned.
REQ-007 SHALL have port cin, input, 1, carry-in.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, consumer takes result.
REQ-010 SHALL have port sum, output, WIDTH, a+b+cin modulo 2^WIDTH.
REQ-011 SHALL have port cout, output, 1, carry out of bit WIDTH-1.
REQ-012 SHALL have port ovf, output, 1, signed overflow; present only per REQ-030.

Function
REQ-013 SHALL sequence one shared 1-bit full-adder cell LSB-first, one bit per clock.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1; in_valid=1 at an edge latches a, b, cin, clears the bit counter, and moves to RUN.
REQ-016 RUN: in_ready=0, out_valid=0; each cycle adds operand bit k plus the carry register, shifts the sum bit into the result register, updates the carry, increments k.
REQ-017 RUN SHALL move to DONE at the edge that processes bit WIDTH-1; out_valid SHALL rise exactly WIDTH cycles after the accepting edge.
REQ-018 DONE: out_valid=1; sum, cout and ovf SHALL hold stable until the edge where out_ready=1, then move to IDLE.
REQ-019 in_valid SHALL be ignored outside IDLE; a new operand set is accepted no earlier than the cycle after result handoff (in_ready only in IDLE).
REQ-020 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within one operation.
REQ-021 WIDTH=1 SHALL work with exactly one RUN cycle.
REQ-022 Operand inputs SHALL NOT be sampled after the accepting edge; changes during RUN or DONE SHALL have no effect.

Reset
REQ-023 rst_n=0 SHALL force state IDLE, the counter and carry to 0, and sum, cout, ovf and out_valid to 0, with in_ready=1 once rst_n=1.
REQ-024 Reset during RUN or DONE SHALL abort the operation; the result SHALL be discarded and never presented.
REQ-025 First acceptance SHALL be possible at the first rising edge after rst_n deasserts.

Configuration
REQ-030 With macro SERIAL_ADD_OVF_EN defined: port ovf exists and equals (carry into bit WIDTH-1) XOR cout, registered at the transition to DONE. Without it: no ovf port and no related logic.

Structure
REQ-031 Package serial_add_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-032 Sub-module serial_fa_cell (combinational) SHALL implement the 1-bit full adder as two half-adder stages: s=x XOR y, c=x AND y per stage, carry out = OR of the stage carries.

Verification
REQ-040 WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, out_valid exactly 8 cycles after accept.
REQ-041 WIDTH=8: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1 (macro on); a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-042 Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum, cout and out_valid stable; in_valid pulses ignored.
REQ-043 Reset mid-run: rst_n=0 at bit 3 of a=0x55, b=0xAA -> out_valid=0, sum=0x00; the next op 0x01+0x02 yields 0x03.
REQ-044 Back-to-back ops with out_ready=1 permanently: 0x10+0x20 then 0x0F+0xF1, cin=1 -> sum 0x30 then sum=0x01, cout=1; 10 cycles per op.
REQ-045 WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1 after 1 RUN cycle.
